// File: rtl/priority_encoder_4to2_seq_if.sv
// rtl/priority_encoder_4to2_seq_if.sv - request/grant bus for the sequential 4-to-2 priority encoder
// The err line exists only when PENC_ERR_EN is defined.
interface priority_encoder_4to2_seq_if;
  logic en;
  logic d3;
  logic d2;
  logic d1;
  logic d0;
  logic ack;
  logic y1;
  logic y0;
  logic v;
  logic gs;
`ifdef PENC_ERR_EN
  logic err;
`endif

  modport master (
    output en, d3, d2, d1, d0, ack,
`ifdef PENC_ERR_EN
    input  err,
`endif
    input  y1, y0, v, gs
  );

  modport slave (
    input  en, d3, d2, d1, d0, ack,
`ifdef PENC_ERR_EN
    output err,
`endif
    output y1, y0, v, gs
  );
endinterface

// File: rtl/priority_encoder_4to2_seq.sv
// rtl/priority_encoder_4to2_seq.sv - pending-request priority encoder with held grant and ack handshake
// Optional sticky coalesce flag err is built only when PENC_ERR_EN is defined.
module priority_encoder_4to2_seq (
  input  logic                          clk,
  input  logic                          rst_n,
  priority_encoder_4to2_seq_if.slave    bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] p;
  logic [3:0] p_nxt;
  logic [3:0] req;
  logic [3:0] cand;
  logic [3:0] grant_mask;
  logic [1:0] y;
  logic [1:0] y_nxt;
  logic [1:0] code;
  logic       v;
  logic       v_nxt;
  logic       gs;

  assign req        = bus.en ? {bus.d3, bus.d2, bus.d1, bus.d0} : 4'b0000;
  assign cand       = p | req;
  assign grant_mask = 4'b0001 << y;

  always_comb begin
    code = 2'b00;
    if (cand[3])      code = 2'b11;
    else if (cand[2]) code = 2'b10;
    else if (cand[1]) code = 2'b01;
  end

  always_comb begin
    state_nxt = state;
    p_nxt     = cand;
    y_nxt     = y;
    v_nxt     = v;
    case (state)
      IDLE: begin
        if (|cand) begin
          y_nxt     = code;
          v_nxt     = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A same-edge re-request of the granted line survives the clear.
        if (bus.ack) begin
          p_nxt     = (p & ~grant_mask) | req;
          v_nxt     = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p     <= 4'b0000;
      y     <= 2'b00;
      v     <= 1'b0;
      gs    <= 1'b0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      y     <= y_nxt;
      v     <= v_nxt;
      gs    <= |p_nxt;
    end
  end

  assign bus.y1 = y[1];
  assign bus.y0 = y[0];
  assign bus.v  = v;
  assign bus.gs = gs;

`ifdef PENC_ERR_EN
  logic err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (|(req & p)) begin
      err <= 1'b1;
    end
  end

  assign bus.err = err;
`endif

endmodule

// File: tb/tb_priority_encoder_4to2_seq.sv
// tb/tb_priority_encoder_4to2_seq.sv - scoreboard bench for priority_encoder_4to2_seq
module tb_priority_encoder_4to2_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic err_obs;

  priority_encoder_4to2_seq_if bus ();

  priority_encoder_4to2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef PENC_ERR_EN
  assign err_obs = bus.err;
`else
  assign err_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] y;
    logic       v;
    logic       gs;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic [3:0] m_p;
  logic       m_hold;
  logic [1:0] m_y;
  logic       m_v;
  logic       m_gs;
  logic       m_err;

  function automatic logic [1:0] highest(input logic [3:0] c);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < 4; i++) if (c[i]) r = i[1:0];
    return r;
  endfunction

  task automatic model_reset();
    m_p = 4'b0000; m_hold = 1'b0; m_y = 2'b00; m_v = 1'b0; m_gs = 1'b0; m_err = 1'b0;
  endtask

  task automatic drive_cycle(input logic en, input logic [3:0] d, input logic ack);
    logic [3:0] dm;
    logic [3:0] c;
    @(negedge clk);
    bus.en = en; {bus.d3, bus.d2, bus.d1, bus.d0} = d; bus.ack = ack;
    dm = en ? d : 4'b0000;
`ifdef PENC_ERR_EN
    if ((dm & m_p) != 4'b0000) m_err = 1'b1;
`endif
    if (!m_hold) begin
      c = m_p | dm;
      if (c != 4'b0000) begin
        m_y = highest(c); m_v = 1'b1; m_hold = 1'b1;
      end
      m_p = c;
    end else if (ack) begin
      m_p = (m_p & ~(4'b0001 << m_y)) | dm;
      m_v = 1'b0; m_hold = 1'b0;
    end else begin
      m_p = m_p | dm;
    end
    m_gs = (m_p != 4'b0000);
    sb.push_back('{y: m_y, v: m_v, gs: m_gs, err: m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 1'b0; {bus.d3, bus.d2, bus.d1, bus.d0} = 4'b0000; bus.ack = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; {bus.d3, bus.d2, bus.d1, bus.d0} = 4'b0000; bus.ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.y1, bus.y0, bus.v, bus.gs, err_obs} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset: got y=%b%b v=%b gs=%b err=%b want all 0", bus.y1, bus.y0, bus.v, bus.gs, err_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input logic [5:0] tbl[$]);
    foreach (tbl[k]) begin
      drive_cycle(tbl[k][5], tbl[k][4:1], tbl[k][0]);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s[%0d]: scoreboard empty, got v=%b want an entry", name, k, bus.v);
      end else begin
        e = sb.pop_front();
        if ({bus.y1, bus.y0, bus.v, bus.gs, err_obs} !== {e.y, e.v, e.gs, e.err}) begin
          miscompares++;
          $display("FAIL %s[%0d]: got y=%b%b v=%b gs=%b err=%b want y=%b v=%b gs=%b err=%b",
                   name, k, bus.y1, bus.y0, bus.v, bus.gs, err_obs, e.y, e.v, e.gs, e.err);
        end
      end
    end
  endtask

  // Table entries are {en, d3, d2, d1, d0, ack}.
  task automatic test_single_hold();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_0100_0, 6'b0_0000_0, 6'b0_0000_0, 6'b0_0000_0, 6'b0_0000_0, 6'b0_0000_0,
          6'b0_0000_1, 6'b0_0000_0};
    run_table("single_hold", t);
    vectors++;
    if ({bus.y1, bus.y0, bus.v, bus.gs} !== 4'b1000) begin
      miscompares++;
      $display("FAIL single_hold_end: got y=%b%b v=%b gs=%b want y=10 v=0 gs=0", bus.y1, bus.y0, bus.v, bus.gs);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_1011_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1, 6'b0_0000_1,
          6'b0_0000_1};
    run_table("back_to_back", t);
  endtask

  task automatic test_no_preempt();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_0010_0, 6'b1_1000_0, 6'b0_0000_0, 6'b0_0000_1, 6'b0_0000_0, 6'b0_0000_1,
          6'b1_0001_0, 6'b0_0000_1};
    run_table("no_preempt", t);
  endtask

  task automatic test_all_pending();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_1111_0, 6'b0_0000_1, 6'b0_0000_0, 6'b0_0000_1, 6'b0_0000_0, 6'b0_0000_1,
          6'b0_0000_0, 6'b0_0000_1, 6'b0_0000_0};
    run_table("all_pending", t);
  endtask

  task automatic test_disabled();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b0_1111_0, 6'b0_1111_1, 6'b0_1111_0, 6'b1_0000_0, 6'b1_0000_1};
    run_table("disabled", t);
  endtask

  task automatic test_async_reset();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_1110_0, 6'b0_0000_0};
    run_table("pre_async", t);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    sb.delete();
    vectors++;
    if ({bus.y1, bus.y0, bus.v, bus.gs, err_obs} !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_reset: got y=%b%b v=%b gs=%b err=%b want all 0", bus.y1, bus.y0, bus.v, bus.gs, err_obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = '{6'b0_0000_0, 6'b1_0000_1, 6'b0_0000_0};
    run_table("post_async", t);
  endtask

  task automatic test_coalesce();
    logic [5:0] t[$];
    apply_reset();
    t = '{6'b1_0001_0, 6'b1_0001_0, 6'b0_0000_1, 6'b0_0000_0, 6'b0_0000_0};
    run_table("coalesce", t);
`ifdef PENC_ERR_EN
    vectors++;
    if (err_obs !== 1'b1) begin
      miscompares++;
      $display("FAIL coalesce_sticky: got err=%b want 1", err_obs);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] t[$];
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      t.push_back({1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) == 0)});
    end
    run_table("random", t);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_no_preempt();
    test_all_pending();
    test_disabled();
    test_async_reset();
    test_coalesce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/priority_encoder_4to2_seq.md
PRIORITY_ENCODER_4TO2_SEQ -- requirements
Module: priority_encoder_4to2_seq

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port EN, input, 1 bit: request capture enable; when 0, D3..D0 are ignored.
REQ-004 The block SHALL have the ports D3, D2, D1, D0, inputs, 1 bit each: request lines, D3 highest priority, D0 lowest.
REQ-005 The block SHALL have the port ACK, input, 1 bit: consumer accepts the presented code.
REQ-006 The block SHALL have the ports Y1, Y0, outputs, 1 bit each: registered 2-bit code of the granted request (Y1 is the MSB).
REQ-007 The block SHALL have the port V, output, 1 bit: registered valid; Y1/Y0 are meaningful only while V=1.
REQ-008 The block SHALL have the port GS, output, 1 bit: registered group signal; 1 when any pending bit is set, including the granted one.
REQ-009 The block SHALL have the port ERR, output, 1 bit, present only with PENC_ERR_EN: sticky coalesce flag.

Function
REQ-010 The block SHALL hold a 4-bit pending register P; at each edge P |= {D3,D2,D1,D0} when EN=1.
REQ-011 The block SHALL implement exactly two FSM states, IDLE and HOLD.
REQ-012 In IDLE, at the edge where C = P | (EN ? D : 0) is nonzero, the block SHALL register Y = the index of the highest set bit of C, set V=1 and go to HOLD; latency from request to V is 1 cycle.
REQ-013 In IDLE with C=0, the block SHALL keep V=0, hold Y at its previous value and stay in IDLE.
REQ-014 In HOLD, the block SHALL keep Y and V stable until ACK=1 is sampled; a higher-priority request arriving during HOLD SHALL NOT pre-empt the grant.
REQ-015 When ACK=1 is sampled in HOLD, the block SHALL clear the granted bit of P, set V=0 and return to IDLE, so there is at least one IDLE cycle between grants.
REQ-016 If the granted bit is re-requested (EN=1) on the same edge as ACK, the block SHALL leave that bit set in P; it is re-granted later.
REQ-017 The block SHALL ignore ACK in IDLE.
REQ-018 Request capture into P SHALL continue in both states, independent of ACK.
REQ-019 GS SHALL equal the registered (next-P != 0) value and SHALL update on the same edge as P.
REQ-020 With pending set P=1111 and no new requests, the block SHALL grant in the order 11, 10, 01, 00.

Reset
REQ-021 While RST_N=0, asynchronously: P=0000, state=IDLE, Y1=0, Y0=0, V=0, GS=0, ERR=0.
REQ-022 A reset asserted mid-HOLD SHALL discard the grant and all pending requests; no ACK is required afterwards.
REQ-023 On the first rising edge after RST_N deasserts, the block SHALL operate normally per REQ-012.

Configuration
REQ-024 With PENC_ERR_EN defined, ERR SHALL be set when EN=1 and any Dn=1 while P[n] is already 1, i.e. the request is coalesced; ERR SHALL remain set until reset.
REQ-025 Without PENC_ERR_EN, the ERR port and its logic SHALL be absent, and coalescing SHALL be silent; all other behaviour is identical.

Verification
REQ-026 Reset then EN=1, D=0100 for 1 cycle, ACK=0 -> next edge Y=10, V=1, GS=1; Y/V hold for 5 cycles; ACK=1 for 1 cycle -> V=0, GS=0.
REQ-027 EN=1, D=1011 for 1 cycle, ACK held at 1 -> grants 11, 01, 00 each with V=1 for 1 cycle and V=0 between grants; GS=0 after the last grant.
REQ-028 In HOLD with Y=01, pulse D3 with EN=1 -> Y stays 01 until ACK; the next grant is 11.
REQ-029 EN=0, D=1111 for 3 cycles -> V=0, GS=0, P=0000.
REQ-030 In HOLD, assert RST_N=0 between edges -> V, Y, GS and ERR are 0 immediately; after release with D=0000, V stays 0.
REQ-031 PENC_ERR_EN defined: EN=1, D=0001 for 2 consecutive cycles without ACK -> ERR=1 after the 2nd edge and stays 1 after ACK; without the macro the same stimulus gives an identical Y/V/GS trace.
